// File: rtl/pixel_writer_pkg.sv
// rtl/pixel_writer_pkg.sv - shared types for the pixel writer
// Purpose: pixel and packed-pair types plus the writer FSM state encoding.
// Ports: none (package).
package pixel_writer_pkg;

    typedef logic [15:0] pixel_t;

    // hi = odd (later) pixel, lo = even (earlier) pixel of a raster pair
    typedef struct packed {
        pixel_t hi;
        pixel_t lo;
    } pixel_pair_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } pixel_writer_state_e;

endpackage

// File: rtl/word_fifo.sv
// rtl/word_fifo.sv - show-ahead word FIFO with async active-low reset
// Purpose: small circular buffer; head entry is visible on rdata_o whenever
//          empty_o is low, and is consumed by pop_i.
// Ports:
//   clock, reset_n   clock and asynchronous active-low reset
//   push_i, wdata_i  write strobe and data (ignored when full)
//   pop_i            consume head entry (ignored when empty)
//   rdata_o          head entry
//   full_o, empty_o  occupancy flags
module word_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             push_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

    // Pointers wrap by natural overflow, which needs a power-of-two depth.
    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("word_fifo: DEPTH must be a power of two >= 2");
    end

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q, count_d;
    logic             do_push, do_pop;

    assign full_o  = (count_q == FULL_CNT);
    assign empty_o = (count_q == '0);
    assign rdata_o = mem_q[rd_ptr_q];

    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            if (do_push) begin
                mem_q[wr_ptr_q] <= wdata_i;
            end
        end
    end

endmodule

// File: rtl/pixel_writer.sv
// rtl/pixel_writer.sv - packs RGB565 pixel pairs and writes a frame over Avalon-MM
// Purpose: final render stage; accepts a raster pixel stream, packs even/odd
//          pairs into 32-bit words and writes them to base_addr + 4*word.
// Ports:
//   clock, reset_n                 clock and asynchronous active-low reset
//   start, base_addr               frame request and buffer byte address
//   busy, frame_done               frame in progress / one-cycle completion
//   px_valid, px_ready, px_color   pixel stream handshake and data
//   m1_address, m1_writedata,
//   m1_write, m1_waitrequest       Avalon-MM write master
module pixel_writer
    import pixel_writer_pkg::*;
#(
    parameter logic [15:0] H_RESOLUTION = 16'd256,
    parameter logic [15:0] V_RESOLUTION = 16'd192,
    parameter int          FIFO_DEPTH   = 4
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        start,
    input  logic [31:0] base_addr,
    output logic        busy,
    output logic        frame_done,
    input  logic        px_valid,
    output logic        px_ready,
    input  logic [15:0] px_color,
    output logic [31:0] m1_address,
    output logic [31:0] m1_writedata,
    output logic        m1_write,
    input  logic        m1_waitrequest
);

    localparam logic [31:0] TOTAL_PIXELS = 32'(H_RESOLUTION) * 32'(V_RESOLUTION);
    localparam logic [31:0] TOTAL_WORDS  = TOTAL_PIXELS >> 1;

    // Rows must hold whole pixel pairs so every word stays inside the frame.
    if (H_RESOLUTION[0] != 1'b0) begin : g_bad_hres
        $error("pixel_writer: H_RESOLUTION must be even");
    end

    pixel_writer_state_e state_q, state_d;
    logic [31:0]         base_q, base_d;
    logic [31:0]         pix_cnt_q, pix_cnt_d;
    logic [31:0]         word_cnt_q, word_cnt_d;
    pixel_t              hold_q, hold_d;

    logic                fifo_full, fifo_empty;
    logic                fifo_push, fifo_pop;
    logic                px_accept;
    pixel_pair_t         fifo_wdata, fifo_rdata;

    // Ready depends on registered state only, never on px_valid.
    assign px_ready  = (state_q == RUN) && !fifo_full;
    assign px_accept = px_valid && px_ready;

    // Odd-index pixel completes a pair and is pushed alongside the held one.
    assign fifo_push  = px_accept && pix_cnt_q[0];
    assign fifo_wdata = '{hi: px_color, lo: hold_q};

    assign m1_write     = !fifo_empty;
    assign fifo_pop     = m1_write && !m1_waitrequest;
    assign m1_address   = base_q + (word_cnt_q << 2);
    assign m1_writedata = fifo_rdata;

    assign busy       = (state_q != IDLE);
    assign frame_done = (state_q == DRAIN) && fifo_empty && (word_cnt_q == TOTAL_WORDS);

    word_fifo #(
        .WIDTH (32),
        .DEPTH (FIFO_DEPTH)
    ) u_word_fifo (
        .clock   (clock),
        .reset_n (reset_n),
        .push_i  (fifo_push),
        .wdata_i (fifo_wdata),
        .pop_i   (fifo_pop),
        .rdata_o (fifo_rdata),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    always_comb begin
        state_d    = state_q;
        base_d     = base_q;
        pix_cnt_d  = pix_cnt_q;
        word_cnt_d = word_cnt_q;
        hold_d     = hold_q;

        if (fifo_pop) begin
            word_cnt_d = word_cnt_q + 32'd1;
        end

        case (state_q)
            IDLE: begin
                if (start) begin
                    base_d     = base_addr;
                    pix_cnt_d  = '0;
                    word_cnt_d = '0;
                    state_d    = RUN;
                end
            end
            RUN: begin
                if (px_accept) begin
                    pix_cnt_d = pix_cnt_q + 32'd1;
                    if (!pix_cnt_q[0]) begin
                        hold_d = px_color;
                    end
                    if (pix_cnt_q == TOTAL_PIXELS - 32'd1) begin
                        state_d = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (frame_done) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            base_q     <= '0;
            pix_cnt_q  <= '0;
            word_cnt_q <= '0;
            hold_q     <= '0;
        end else begin
            state_q    <= state_d;
            base_q     <= base_d;
            pix_cnt_q  <= pix_cnt_d;
            word_cnt_q <= word_cnt_d;
            hold_q     <= hold_d;
        end
    end

endmodule

// File: tb/tb_pixel_writer.sv
// tb/tb_pixel_writer.sv - scoreboard bench for pixel_writer
module tb_pixel_writer;

    localparam logic [15:0] H  = 16'd32;
    localparam logic [15:0] V  = 16'd6;
    localparam int          TP = int'(H) * int'(V);
    localparam int          TW = TP / 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [31:0] base_addr = '0;
    logic        busy, frame_done;
    logic        px_valid = 1'b0;
    logic        px_ready;
    logic [15:0] px_color = '0;
    logic [31:0] m1_address, m1_writedata;
    logic        m1_write;
    logic        m1_waitrequest = 1'b0;

    pixel_writer #(
        .H_RESOLUTION (H),
        .V_RESOLUTION (V),
        .FIFO_DEPTH   (4)
    ) dut (
        .clock          (clk),
        .reset_n        (rst_n),
        .start          (start),
        .base_addr      (base_addr),
        .busy           (busy),
        .frame_done     (frame_done),
        .px_valid       (px_valid),
        .px_ready       (px_ready),
        .px_color       (px_color),
        .m1_address     (m1_address),
        .m1_writedata   (m1_writedata),
        .m1_write       (m1_write),
        .m1_waitrequest (m1_waitrequest)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // waitrequest generator: forced stall or random stalls
    bit force_wait = 1'b0;
    bit rand_wait  = 1'b0;
    always @(posedge clk) begin
        #2;
        m1_waitrequest = force_wait || (rand_wait && ($urandom_range(0, 2) == 0));
    end

    // reference frame contents and expected word queue {addr, data}
    logic [15:0] pix [TP];
    logic [63:0] exp_q [$];

    int          wr_seen = 0;
    int          fd_count = 0;
    int          fd_cyc = 0;
    logic        busy_at_fd = 1'b0;
    logic [31:0] first_addr = '0, first_data = '0, last_addr = '0, last_data = '0;

    // monitor: compares every accepted write against the scoreboard
    always @(negedge clk) begin
        logic [63:0] e;
        if (rst_n && m1_write && !m1_waitrequest) begin
            if (wr_seen == 0) begin
                first_addr = m1_address;
                first_data = m1_writedata;
            end
            last_addr = m1_address;
            last_data = m1_writedata;
            wr_seen++;
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL spurious_write: got addr %h data %h expected no write", m1_address, m1_writedata);
            end else begin
                e = exp_q.pop_front();
                check("wr_addr", m1_address, e[63:32]);
                check("wr_data", m1_writedata, e[31:0]);
            end
        end
        if (frame_done) begin
            fd_count++;
            fd_cyc     = cyc;
            busy_at_fd = busy;
        end
    end

    task automatic fill(input bit rnd);
        for (int i = 0; i < TP; i++) begin
            pix[i] = rnd ? 16'($urandom) : 16'(i);
        end
    endtask

    task automatic start_frame(input logic [31:0] b, input bit push_exp);
        if (push_exp) begin
            for (int w = 0; w < TW; w++) begin
                exp_q.push_back({b + 32'(4 * w), pix[2*w+1], pix[2*w]});
            end
        end
        wr_seen   = 0;
        base_addr = b;
        start     = 1'b1;
        @(posedge clk); #1;
        start     = 1'b0;
        base_addr = $urandom;
    endtask

    int last_acc_cyc = 0;

    task automatic drive_frame(input bit gaps);
        int i = 0;
        int guard = 0;
        bit acc;
        while (i < TP && guard < 5000) begin
            px_valid = gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
            px_color = pix[i];
            @(negedge clk);
            acc = px_valid && px_ready;
            if (acc) last_acc_cyc = cyc;
            @(posedge clk); #1;
            if (acc) i++;
            guard++;
        end
        px_valid = 1'b0;
        check("pixels_accepted", 32'(i), 32'(TP));
    endtask

    task automatic wait_done(input int fd0);
        int n = 0;
        while (fd_count == fd0 && n < 3000) begin
            @(posedge clk); #1;
            n++;
        end
        check("frame_done_seen", 32'(fd_count), 32'(fd0 + 1));
        check("busy_at_done", 32'(busy_at_fd), 32'd1);
        check("busy_after_done", 32'(busy), 32'd0);
        repeat (4) @(posedge clk);
        #1;
        check("single_frame_done", 32'(fd_count), 32'(fd0 + 1));
        check("write_count", 32'(wr_seen), 32'(TW));
        check("queue_empty", 32'(exp_q.size()), 32'd0);
    endtask

    task automatic run_frame(input logic [31:0] b, input bit rnd, input bit gaps);
        int fd0;
        fill(rnd);
        fd0 = fd_count;
        start_frame(b, 1'b1);
        drive_frame(gaps);
        wait_done(fd0);
    endtask

    task automatic stall_word2(input logic [31:0] b);
        int n = 0;
        while (!(m1_write && m1_address == b + 32'd8) && n < 500) begin
            @(posedge clk); #1;
            n++;
        end
        check("stall_word2_found", m1_address, b + 32'd8);
        force_wait = 1'b1;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            check("stall_addr", m1_address, b + 32'd8);
            check("stall_data", m1_writedata, {pix[5], pix[4]});
        end
        check("px_ready_full", 32'(px_ready), 32'd0);
        @(posedge clk); #1;
        force_wait = 1'b0;
        n = 0;
        while (!px_ready && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        check("px_ready_recover", 32'(px_ready), 32'd1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int fd0;
        logic [31:0] b;

        // 1: reset state, then idle with no start
        #12;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_px_ready", 32'(px_ready), 32'd0);
        check("rst_m1_write", 32'(m1_write), 32'd0);
        check("rst_frame_done", 32'(frame_done), 32'd0);
        check("rst_addr", m1_address, 32'd0);
        check("rst_data", m1_writedata, 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        check("idle_busy", 32'(busy), 32'd0);
        check("idle_px_ready", 32'(px_ready), 32'd0);
        check("idle_m1_write", 32'(m1_write), 32'd0);
        check("idle_fd_count", 32'(fd_count), 32'd0);

        // 2: full frame, index pixels, no stalls
        fill(1'b0);
        fd0 = fd_count;
        start_frame(32'h0800_0000, 1'b1);
        drive_frame(1'b0);
        wait_done(fd0);
        check("first_addr", first_addr, 32'h0800_0000);
        check("first_data", first_data, 32'h0001_0000);
        check("last_addr", last_addr, 32'h0800_0000 + 32'(4 * (TW - 1)));
        check("last_data", last_data, {16'(TP - 1), 16'(TP - 2)});
        check("done_latency", 32'(fd_cyc), 32'(last_acc_cyc + 2));

        // 3: 8-cycle stall on word 2
        fill(1'b0);
        fd0 = fd_count;
        start_frame(32'h0800_0000, 1'b1);
        fork
            drive_frame(1'b0);
            stall_word2(32'h0800_0000);
        join
        wait_done(fd0);

        // 4: random gaps and stalls, three frames, one base near the wrap
        rand_wait = 1'b1;
        for (int f = 0; f < 3; f++) begin
            b = (f == 1) ? 32'hFFFF_FF80 : $urandom;
            run_frame(b, 1'b1, 1'b1);
        end
        rand_wait = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        // 5: start during RUN with a new base is ignored
        fill(1'b0);
        fd0 = fd_count;
        start_frame(32'h0400_0000, 1'b1);
        fork
            drive_frame(1'b0);
            begin
                repeat (20) @(posedge clk);
                #1;
                start     = 1'b1;
                base_addr = 32'h1000_0000;
                @(posedge clk); #1;
                start     = 1'b0;
            end
        join
        wait_done(fd0);
        check("ignored_start_first_addr", first_addr, 32'h0400_0000);

        // 6: async reset mid-frame while m1_write is high, then a clean frame
        fill(1'b0);
        force_wait = 1'b1;
        start_frame(32'h0200_0000, 1'b0);
        px_valid = 1'b1;
        px_color = 16'h1234;
        begin
            int n = 0;
            while (!m1_write && n < 50) begin
                @(posedge clk); #1;
                n++;
            end
        end
        check("pre_reset_m1_write", 32'(m1_write), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_m1_write", 32'(m1_write), 32'd0);
        check("async_busy", 32'(busy), 32'd0);
        check("async_px_ready", 32'(px_ready), 32'd0);
        check("async_addr", m1_address, 32'd0);
        px_valid   = 1'b0;
        force_wait = 1'b0;
        exp_q.delete();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        run_frame(32'h0300_0000, 1'b1, 1'b0);
        check("after_reset_first_addr", first_addr, 32'h0300_0000);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
